// File: rtl/tpu_pkg.sv
// Shared Q8.8 constants, accumulator state encoding and the saturating narrow
// helper used by every bias-gradient column.
package tpu_pkg;

  localparam int INT_W       = 8;
  localparam int FRAC_W      = 8;
  localparam int DATA_W      = INT_W + FRAC_W;
  localparam int NARROW_IN_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              clamped;
  } narrow_t;

  // Clamp a wide signed Q8.8 value into DATA_W bits, flagging any clamp.
  function automatic narrow_t sat_narrow(input logic signed [NARROW_IN_W-1:0] v);
    narrow_t r;
    if (v > 32'sh0000_7FFF) begin
      r.data    = 16'h7FFF;
      r.clamped = 1'b1;
    end else if (v < 32'shFFFF_8000) begin
      r.data    = 16'h8000;
      r.clamped = 1'b1;
    end else begin
      r.data    = v[DATA_W-1:0];
      r.clamped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bias_grad_acc_column.sv
// One column of the bias-gradient accumulator: running sum, row counter,
// done detection and narrowing. Saturation enabled by GRAD_ACC_SATURATE_EN.
module bias_grad_acc_column #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [CNT_W-1:0]  size_i,
  input  logic [DATA_W-1:0] grad_i,
  input  logic              valid_i,
  output logic              done_o,
  output logic [DATA_W-1:0] narrow_o,
  output logic              clamp_o
);
  import tpu_pkg::*;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    take;

  // Rows beyond the latched batch size are silently dropped.
  assign take = en_i && valid_i && (cnt_q < size_i);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take) begin
      acc_d = acc_q + ACC_W'(signed'(grad_i));
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Done includes this cycle's add so the FSM can leave ACCUM on the same edge.
  assign done_o = (cnt_d == size_i);

`ifdef GRAD_ACC_SATURATE_EN
  narrow_t nar;
  always_comb begin
    nar      = sat_narrow(NARROW_IN_W'(acc_d));
    narrow_o = nar.data;
    clamp_o  = nar.clamped;
  end
`else
  assign narrow_o = acc_d[DATA_W-1:0];
  assign clamp_o  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bias_grad_accumulator.sv
// Two-column batch sum of dL/dH into bias gradients, presented via valid/ready.
// Optional output saturation: define GRAD_ACC_SATURATE_EN.
module bias_grad_accumulator #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 24,
  parameter int MAX_BATCH = 16,
  localparam int CNT_W    = $clog2(MAX_BATCH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [CNT_W-1:0]  batch_size_in,
  input  logic [DATA_W-1:0] grad_1_in,
  input  logic [DATA_W-1:0] grad_2_in,
  input  logic              valid_1_in,
  input  logic              valid_2_in,
  input  logic              out_ready_in,
  output logic [DATA_W-1:0] bias_grad_1_out,
  output logic [DATA_W-1:0] bias_grad_2_out,
  output logic              valid_out,
  output logic              busy_out,
  output logic              overflow_out
);
  import tpu_pkg::*;

  acc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  size_q, size_d;
  logic [DATA_W-1:0] bias1_q, bias1_d, bias2_q, bias2_d;
  logic              ovf_q, ovf_d;
  logic              start_ok, in_accum;

  logic [1:0][DATA_W-1:0] grad_v, narrow_v;
  logic [1:0]             valid_v, done_v, clamp_v;

  assign grad_v  = {grad_2_in, grad_1_in};
  assign valid_v = {valid_2_in, valid_1_in};

  assign start_ok = (state_q == ST_IDLE) && start_in && (batch_size_in != '0)
                    && (batch_size_in <= CNT_W'(MAX_BATCH));
  assign in_accum = (state_q == ST_ACCUM);

  for (genvar gi = 0; gi < 2; gi++) begin : g_col
    bias_grad_acc_column #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
    ) u_col (
      .clk     (clk),
      .rst     (rst),
      .clear_i (start_ok),
      .en_i    (in_accum),
      .size_i  (size_q),
      .grad_i  (grad_v[gi]),
      .valid_i (valid_v[gi]),
      .done_o  (done_v[gi]),
      .narrow_o(narrow_v[gi]),
      .clamp_o (clamp_v[gi])
    );
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    bias1_d = bias1_q;
    bias2_d = bias2_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_ACCUM;
          size_d  = batch_size_in;
          ovf_d   = 1'b0;
        end
      end
      ST_ACCUM: begin
        // Results are captured on the edge that completes the later column.
        if (&done_v) begin
          state_d = ST_HOLD;
          bias1_d = narrow_v[0];
          bias2_d = narrow_v[1];
          ovf_d   = ovf_q | (|clamp_v);
        end
      end
      ST_HOLD: begin
        if (out_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      bias1_q <= '0;
      bias2_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      bias1_q <= bias1_d;
      bias2_q <= bias2_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bias_grad_1_out = bias1_q;
  assign bias_grad_2_out = bias2_q;
  assign valid_out       = (state_q == ST_HOLD);
  assign busy_out        = (state_q != ST_IDLE);
  assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_bias_grad_accumulator.sv
// Scoreboard bench for bias_grad_accumulator: directed cases plus randomized
// batches against a plain-arithmetic sum model (honours GRAD_ACC_SATURATE_EN).
module tb_bias_grad_accumulator;
  localparam int DATA_W    = 16;
  localparam int ACC_W     = 24;
  localparam int MAX_BATCH = 16;
  localparam int CNT_W     = $clog2(MAX_BATCH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_in = 1'b0;
  logic [CNT_W-1:0]  batch_size_in = '0;
  logic [DATA_W-1:0] grad_1_in = '0, grad_2_in = '0;
  logic              valid_1_in = 1'b0, valid_2_in = 1'b0;
  logic              out_ready_in = 1'b0;
  logic [DATA_W-1:0] bias_grad_1_out, bias_grad_2_out;
  logic              valid_out, busy_out, overflow_out;

  always #5 clk = ~clk;

  bias_grad_accumulator #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_BATCH(MAX_BATCH)
  ) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .batch_size_in(batch_size_in),
    .grad_1_in(grad_1_in), .grad_2_in(grad_2_in),
    .valid_1_in(valid_1_in), .valid_2_in(valid_2_in),
    .out_ready_in(out_ready_in),
    .bias_grad_1_out(bias_grad_1_out), .bias_grad_2_out(bias_grad_2_out),
    .valid_out(valid_out), .busy_out(busy_out), .overflow_out(overflow_out)
  );

  typedef struct packed {
    logic [15:0] b1;
    logic [15:0] b2;
    logic        ov;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          results = 0;
  logic [15:0] g1 [MAX_BATCH];
  logic [15:0] g2 [MAX_BATCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference narrowing of an exact integer sum: returns {clamped, data}.
  function automatic logic [16:0] ref_narrow(input int s);
    logic [31:0] u;
    logic [15:0] d;
    logic        ov;
    u  = s;
    d  = u[15:0];
    ov = 1'b0;
`ifdef GRAD_ACC_SATURATE_EN
    if (s > 32767) begin
      d = 16'h7FFF; ov = 1'b1;
    end else if (s < -32768) begin
      d = 16'h8000; ov = 1'b1;
    end
`endif
    return {ov, d};
  endfunction

  // Monitor: pops an expectation when a result appears, then checks it stays put.
  initial begin : monitor
    logic        prev_v;
    exp_t        e;
    logic [15:0] h1, h2;
    logic        hov;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_out && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          results++;
          $display("[TB] result %0d: col1=%h col2=%h ovf=%b (want %h %h %b)",
                   results, bias_grad_1_out, bias_grad_2_out, overflow_out, e.b1, e.b2, e.ov);
          check("bias1", bias_grad_1_out, e.b1);
          check("bias2", bias_grad_2_out, e.b2);
          check("overflow", overflow_out, e.ov);
        end
        h1 = bias_grad_1_out; h2 = bias_grad_2_out; hov = overflow_out;
      end else if (valid_out && prev_v) begin
        check("hold_bias1_stable", bias_grad_1_out, h1);
        check("hold_bias2_stable", bias_grad_2_out, h2);
        check("hold_ovf_stable", overflow_out, hov);
      end
      prev_v = valid_out;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // mode 0: random per-column valids; 1: column 2 one cycle behind column 1
  // (column 1 keeps asserting valid, so it offers extra rows); 2: same cycle.
  task automatic drive_batch(input int size, input int mode);
    int          n1 = 0, n2 = 0, cyc = 0, s1 = 0, s2 = 0;
    logic        v1, v2;
    logic [16:0] r1, r2;
    exp_t        e;
    for (int i = 0; i < size; i++) begin
      s1 += int'($signed(g1[i]));
      s2 += int'($signed(g2[i]));
    end
    r1 = ref_narrow(s1);
    r2 = ref_narrow(s2);
    e.b1 = r1[15:0];
    e.b2 = r2[15:0];
    e.ov = r1[16] | r2[16];
    exp_q.push_back(e);
    start_in      = 1'b1;
    batch_size_in = CNT_W'(size);
    @(negedge clk);
    start_in = 1'b0;
    check("busy_rise", busy_out, 32'd1);
    while ((n1 < size || n2 < size) && cyc < 200) begin
      check("no_early_valid", valid_out, 32'd0);
      case (mode)
        0:       begin v1 = 1'($urandom_range(0, 1)); v2 = 1'($urandom_range(0, 1)); end
        1:       begin v1 = 1'b1; v2 = (cyc > 0); end
        default: begin v1 = 1'b1; v2 = 1'b1; end
      endcase
      valid_1_in    = v1;
      valid_2_in    = v2;
      grad_1_in     = (n1 < size) ? g1[n1] : 16'($urandom);
      grad_2_in     = (n2 < size) ? g2[n2] : 16'($urandom);
      out_ready_in  = 1'($urandom_range(0, 1));
      start_in      = 1'($urandom_range(0, 1));
      batch_size_in = CNT_W'($urandom_range(1, MAX_BATCH));
      if (v1) n1++;
      if (v2) n2++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) check("accum_timeout", 32'd1, 32'd0);
    valid_1_in   = 1'b0;
    valid_2_in   = 1'b0;
    start_in     = 1'b0;
    out_ready_in = 1'b0;
    check("valid_latency", valid_out, 32'd1);
  endtask

  task automatic hold_phase(input int low);
    for (int i = 0; i < low; i++) begin
      out_ready_in  = 1'b0;
      valid_1_in    = 1'($urandom_range(0, 1));
      valid_2_in    = 1'($urandom_range(0, 1));
      grad_1_in     = 16'($urandom);
      grad_2_in     = 16'($urandom);
      start_in      = 1'($urandom_range(0, 1));
      batch_size_in = CNT_W'($urandom_range(1, MAX_BATCH));
      @(negedge clk);
      check("hold_valid", valid_out, 32'd1);
      check("hold_busy", busy_out, 32'd1);
    end
    valid_1_in   = 1'b0;
    valid_2_in   = 1'b0;
    start_in     = 1'b0;
    out_ready_in = 1'b1;
    @(negedge clk);
    out_ready_in = 1'b0;
    check("accept_valid_drop", valid_out, 32'd0);
    check("accept_busy_drop", busy_out, 32'd0);
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < MAX_BATCH; i++) begin
      g1[i] = v;
      g2[i] = v;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < MAX_BATCH; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        g1[i] = 16'($urandom_range(0, 16'h1000) - 16'h0800);
        g2[i] = 16'($urandom_range(0, 16'h1000) - 16'h0800);
      end else begin
        g1[i] = 16'($urandom);
        g2[i] = 16'($urandom);
      end
    end
  endtask

  task automatic bad_start(input int size);
    start_in      = 1'b1;
    batch_size_in = CNT_W'(size);
    @(negedge clk);
    start_in = 1'b0;
    check("bad_start_busy", busy_out, 32'd0);
    @(negedge clk);
    check("bad_start_busy_later", busy_out, 32'd0);
    check("bad_start_valid", valid_out, 32'd0);
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check("rst_bias1", bias_grad_1_out, 32'd0);
    check("rst_bias2", bias_grad_2_out, 32'd0);
    check("rst_valid", valid_out, 32'd0);
    check("rst_busy", busy_out, 32'd0);
    check("rst_ovf", overflow_out, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    fill_const(16'h0100);
    drive_batch(4, 1);
    hold_phase(1);

    g1[0] = 16'h0080; g1[1] = 16'hFF00; g1[2] = 16'h0040;
    g2[0] = 16'h0080; g2[1] = 16'hFF00; g2[2] = 16'h0040;
    drive_batch(3, 2);
    hold_phase(0);

    fill_const(16'h7000);
    drive_batch(4, 0);
    hold_phase(5);

    // Start on the edge right after the handshake.
    fill_random();
    drive_batch(5, 2);
    hold_phase(2);

    bad_start(0);
    bad_start(MAX_BATCH + 1);

    fill_const(16'h0100);
    drive_batch(4, 1);
    hold_phase(0);

    // Abort a batch after two of four rows.
    fill_const(16'h0100);
    start_in      = 1'b1;
    batch_size_in = CNT_W'(4);
    @(negedge clk);
    start_in   = 1'b0;
    valid_1_in = 1'b1; valid_2_in = 1'b1;
    grad_1_in  = 16'h0100; grad_2_in = 16'h0100;
    repeat (2) @(negedge clk);
    valid_1_in = 1'b0; valid_2_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_bias1", bias_grad_1_out, 32'd0);
    check("midrst_bias2", bias_grad_2_out, 32'd0);
    check("midrst_valid", valid_out, 32'd0);
    check("midrst_busy", busy_out, 32'd0);
    check("midrst_ovf", overflow_out, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    drive_batch(2, 2);
    hold_phase(1);

    for (int b = 0; b < 30; b++) begin
      fill_random();
      drive_batch($urandom_range(1, MAX_BATCH), $urandom_range(0, 2));
      hold_phase($urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
